serial_bit_feeder: RTL and testbench

Upstream stage for the 1111001 sequence detector. Accepts parallel words over a valid/ready handshake and serializes them into the one-bit-per-clock stream `x` that the detector samples. A one-word holding buffer lets back-to-back words stream with no idle cycles between them. When no data is pending, the line is driven to a defined idle level.

---
 rtl/serial_bit_feeder_pkg.sv | 13 +
 rtl/serial_bit_feeder.sv | 118 +++++++++++
 tb/tb_serial_bit_feeder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder that drives the 1111001 detector.
// Holds the feeder state encoding and the default word width / idle line level.
package feeder_pkg;

   typedef enum logic {
      FEED_IDLE  = 1'b0,
      FEED_SHIFT = 1'b1
   } feed_state_e;

   localparam int   DEF_WIDTH    = 8;
   localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/serial_bit_feeder.sv
// Serializes valid/ready parallel words into a one-bit-per-clock stream for the
// 1111001 detector; a one-word holding buffer keeps consecutive words gap-free.
module serial_bit_feeder
   import feeder_pkg::*;
#(
   parameter int   WIDTH     = DEF_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic [15:0]      words_sent
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

   feed_state_e      state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] hold, hold_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             hold_full, hold_full_n;
   logic             last_bit, xfer, sent_inc;

   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
      if (MSB_FIRST)
         return {v[WIDTH-2:0], 1'b0};
      else
         return {1'b0, v[WIDTH-1:1]};
   endfunction

   assign last_bit = (cnt == '0);
   assign in_ready = !hold_full && !flush;
   assign xfer     = in_valid && in_ready;
   assign busy     = (state == FEED_SHIFT) || hold_full;
   assign x_valid  = (state == FEED_SHIFT);
   // x is derived only from registered state, so in_data/in_valid never reach it.
   assign x        = x_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;

   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      hold_n      = hold;
      cnt_n       = cnt;
      hold_full_n = hold_full;
      sent_inc    = 1'b0;
      if (flush) begin
         state_n     = FEED_IDLE;
         shreg_n     = '0;
         hold_n      = '0;
         cnt_n       = '0;
         hold_full_n = 1'b0;
      end else begin
         unique case (state)
            FEED_IDLE: begin
               if (xfer) begin
                  shreg_n = in_data;
                  cnt_n   = CNT_LOAD;
                  state_n = FEED_SHIFT;
               end
            end
            FEED_SHIFT: begin
               if (last_bit) begin
                  sent_inc = 1'b1;
                  if (hold_full) begin
                     shreg_n     = hold;
                     cnt_n       = CNT_LOAD;
                     hold_full_n = 1'b0;
                  end else if (xfer) begin
                     shreg_n = in_data;
                     cnt_n   = CNT_LOAD;
                  end else begin
                     state_n = FEED_IDLE;
                  end
               end else begin
                  shreg_n = shift_once(shreg);
                  cnt_n   = cnt - 1'b1;
                  if (xfer) begin
                     hold_n      = in_data;
                     hold_full_n = 1'b1;
                  end
               end
            end
            default: state_n = FEED_IDLE;
         endcase
      end
   end

   // control registers: asynchronous reset drops any partial word at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FEED_IDLE;
         hold_full  <= 1'b0;
         cnt        <= '0;
         words_sent <= '0;
      end else begin
         state     <= state_n;
         hold_full <= hold_full_n;
         cnt       <= cnt_n;
         if (sent_inc)
            words_sent <= words_sent + 16'd1;
      end
   end

   // data registers: meaningful only while qualified by state / hold_full
   always_ff @(posedge clk) begin
      shreg <= shreg_n;
      hold  <= hold_n;
   end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus
// and are checked each cycle against a word-queue model of the feeder.
module tb_serial_bit_feeder;

   localparam int   W    = 8;
   localparam logic IDLE = 1'b0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;

   logic         rdy_m, x_m, xv_m, busy_m;
   logic         rdy_l, x_l, xv_l, busy_l;
   logic [15:0]  sent_m, sent_l;

   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
      .flush(flush), .x(x_m), .x_valid(xv_m), .busy(busy_m), .words_sent(sent_m));

   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
      .flush(flush), .x(x_l), .x_valid(xv_l), .busy(busy_l), .words_sent(sent_l));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model: active word with bit position, plus queue of waiting words
   logic         m_act;
   logic [W-1:0] m_w;
   int           m_pos;
   logic [W-1:0] m_q[$];
   int           m_sent;

   // samples captured at the last step
   logic s_xm, s_xl, s_xv, s_rdy;
   logic m_rdy_last;
   int   cyc_no = 0;
   logic [6:0] hist_m, hist_l;
   int   hits_m, hits_l;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         f;
      logic         ex_m;
      logic         ex_l;
      logic         exv;
      logic         erdy;
   } vec_t;
   vec_t tbl[10];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void m_start(input logic [W-1:0] w);
      m_act = 1'b1;
      m_w   = w;
      m_pos = 0;
   endfunction

   function automatic void m_reset();
      m_act  = 1'b0;
      m_w    = '0;
      m_pos  = 0;
      m_q.delete();
      m_sent = 0;
   endfunction

   // one clock: drive inputs, compare at negedge, advance model, return at posedge+1
   task automatic step(input logic v, input logic [W-1:0] d, input logic f);
      logic e_xm, e_xl, e_rdy, e_busy, was_act, xfer, taken;
      in_valid = v;
      in_data  = d;
      flush    = f;
      @(negedge clk);
      e_xm   = m_act ? m_w[W-1-m_pos] : IDLE;
      e_xl   = m_act ? m_w[m_pos] : IDLE;
      e_rdy  = (m_q.size() == 0) && !f;
      e_busy = m_act || (m_q.size() != 0);
      chk("x_msb", 32'(x_m), 32'(e_xm));
      chk("x_lsb", 32'(x_l), 32'(e_xl));
      chk("x_valid_msb", 32'(xv_m), 32'(m_act));
      chk("x_valid_lsb", 32'(xv_l), 32'(m_act));
      chk("in_ready", 32'({rdy_m, rdy_l}), 32'({e_rdy, e_rdy}));
      chk("busy", 32'({busy_m, busy_l}), 32'({e_busy, e_busy}));
      chk("words_sent", 32'({sent_m, sent_l}), {16'(m_sent), 16'(m_sent)});
      s_xm = x_m; s_xl = x_l; s_xv = xv_m; s_rdy = rdy_m;
      m_rdy_last = e_rdy;
      if (xv_m) begin
         hist_m = {hist_m[5:0], x_m};
         if (hist_m == 7'b1111001) hits_m++;
      end
      if (xv_l) begin
         hist_l = {hist_l[5:0], x_l};
         if (hist_l == 7'b1111001) hits_l++;
      end
      if (f) begin
         m_act = 1'b0;
         m_q.delete();
      end else begin
         xfer    = v && e_rdy;
         taken   = 1'b0;
         was_act = m_act;
         if (m_act) begin
            m_pos++;
            if (m_pos == W) begin
               m_sent = (m_sent + 1) % 65536;
               m_act  = 1'b0;
               if (m_q.size() != 0) m_start(m_q.pop_front());
               else if (xfer) begin
                  m_start(d);
                  taken = 1'b1;
               end
            end
         end
         if (xfer && !taken) begin
            if (!was_act) m_start(d);
            else m_q.push_back(d);
         end
      end
      cyc_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_x"}, 32'({x_m, x_l}), 32'({IDLE, IDLE}));
      chk({tag, "_x_valid"}, 32'({xv_m, xv_l}), 32'd0);
      chk({tag, "_busy"}, 32'({busy_m, busy_l}), 32'd0);
      chk({tag, "_words_sent"}, 32'({sent_m, sent_l}), 32'd0);
   endtask

   initial begin
      int first, last, xv_cnt, ready_low, idx, base, guard;
      logic [W-1:0] words[3];

      // single F2 word: MSB stream 11110010, LSB stream 01001111
      tbl[0] = '{1'b1, 8'hF2, 1'b0, IDLE, IDLE, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 8'h00, 1'b0, IDLE, IDLE, 1'b0, 1'b1};

      m_reset();
      hist_m = '0; hist_l = '0; hits_m = 0; hits_l = 0;
      #1;
      check_reset_outputs("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].f);
         chk($sformatf("tbl%0d_x_msb", i), 32'(s_xm), 32'(tbl[i].ex_m));
         chk($sformatf("tbl%0d_x_lsb", i), 32'(s_xl), 32'(tbl[i].ex_l));
         chk($sformatf("tbl%0d_x_valid", i), 32'(s_xv), 32'(tbl[i].exv));
         chk($sformatf("tbl%0d_in_ready", i), 32'(s_rdy), 32'(tbl[i].erdy));
      end
      chk("single_words_sent", 32'(sent_m), 32'd1);
      chk("single_detector_hits", 32'(hits_m), 32'd1);

      // back-to-back with backpressure on the third word
      words[0] = 8'hF2; words[1] = 8'hA5; words[2] = 8'h0F;
      first = -1; last = -1; xv_cnt = 0; ready_low = 0; idx = 0; guard = 0;
      base = m_sent;
      while ((idx < 3 || m_act || m_q.size() != 0) && guard < 100) begin
         step(idx < 3, (idx < 3) ? words[idx] : 8'h00, 1'b0);
         if (s_xv) begin
            if (first < 0) first = cyc_no;
            last = cyc_no;
            xv_cnt++;
         end
         if (idx < 3 && !s_rdy) ready_low++;
         if (idx < 3 && m_rdy_last) idx++;
         guard++;
      end
      chk("b2b_timeout", 32'(guard < 100), 32'd1);
      chk("b2b_xvalid_cycles", 32'(xv_cnt), 32'd24);
      chk("b2b_no_gap", 32'(last - first + 1), 32'd24);
      chk("b2b_ready_low_cycles", 32'(ready_low), 32'd7);
      chk("b2b_words_sent", 32'(sent_m), 32'(base + 3));

      // flush at bit 3 of FF with 00 waiting in hold
      base = m_sent;
      step(1'b1, 8'hFF, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_x_valid", 32'({xv_m, xv_l}), 32'd0);
      chk("flush_busy", 32'({busy_m, busy_l}), 32'd0);
      chk("flush_in_ready", 32'({rdy_m, rdy_l}), 32'd3);
      chk("flush_words_sent", 32'(sent_m), 32'(base));
      @(posedge clk); #1;

      // asynchronous reset in the middle of F2
      step(1'b1, 8'hF2, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      step(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0);
      chk("post_rst_words_sent", 32'(sent_m), 32'd1);

      // LSB-first 4F reproduces the detector pattern
      hist_l = '0; hits_l = 0;
      step(1'b1, 8'h4F, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0);
      chk("lsb_4f_detector_hits", 32'(hits_l), 32'd1);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 40) == 0);
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
